// File: rtl/matrix_prog_ctrl_pkg.sv
// Shared definitions for the matrix programming controller: FSM state
// encoding and the command address field layout.
package matrix_prog_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_RWAIT,
      ST_RESP,
      ST_SWEEP_SETUP,
      ST_SWEEP_STROBE
   } state_e;

   // Address layout: {must-be-zero, vh, s_addr, d_addr}
   localparam int unsigned D_LSB = 0;

   function automatic int unsigned s_lsb(input int unsigned logn);
      return logn;
   endfunction

   function automatic int unsigned vh_bit(input int unsigned logn);
      return 2 * logn;
   endfunction

endpackage

// File: rtl/matrix_prog_ctrl_addr_decode.sv
// Combinational split of a command address into destination, source,
// vertical/horizontal select and a decode error for nonzero upper bits.
module prog_addr_decode
   import matrix_prog_ctrl_pkg::*;
#(
   parameter int unsigned LOGN = 3
)
(
   input  logic [31:0]     addr_i,
   output logic [LOGN-1:0] s_o,
   output logic [LOGN-1:0] d_o,
   output logic            vh_o,
   output logic            err_o
);

   localparam int unsigned S_LSB  = s_lsb(LOGN);
   localparam int unsigned VH_BIT = vh_bit(LOGN);

   // Field extraction; any bit above vh flags the address as invalid
   always_comb begin
      d_o   = addr_i[D_LSB +: LOGN];
      s_o   = addr_i[S_LSB +: LOGN];
      vh_o  = addr_i[VH_BIT];
      err_o = |(addr_i >> (VH_BIT + 1));
   end

endmodule

// File: rtl/matrix_prog_ctrl.sv
// Command/response front end for a crosspoint matrix: single reads and
// writes through a handshake, plus a full-matrix fill sweep.
module matrix_prog_ctrl
   import matrix_prog_ctrl_pkg::*;
#(
   parameter  int unsigned N      = 8,
   parameter  int unsigned RD_LAT = 1,
   localparam int unsigned LOGN   = $clog2(N)
)
(
   input  logic            clk,
   input  logic            axi_rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_write,
   input  logic [31:0]     cmd_addr,
   input  logic [31:0]     cmd_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [31:0]     rsp_rdata,
   output logic            rsp_err,
   input  logic            sweep_start,
   input  logic [31:0]     sweep_wdata,
   output logic            sweep_busy,
   output logic            sweep_done,
   output logic [LOGN:0]   s_addr,
   output logic [LOGN:0]   d_addr,
   output logic            vh,
   output logic            wr_match,
   output logic            wready,
   output logic [31:0]     wdata,
   input  logic [31:0]     rdata
);

   localparam int unsigned IW       = 2 * LOGN + 1;
   localparam int unsigned S_LSB    = s_lsb(LOGN);
   localparam int unsigned VH_BIT   = vh_bit(LOGN);
   localparam logic [1:0]  LAT_INIT = 2'(RD_LAT - 1);

   state_e            state_q;
   logic [IW-1:0]     idx_q;
   logic [IW-1:0]     idx_d;
   logic [1:0]        lat_q;
   logic              is_wr_q;

   logic              cmd_ready_q;
   logic              rsp_valid_q;
   logic [31:0]       rsp_rdata_q;
   logic              rsp_err_q;
   logic              busy_q;
   logic              done_q;
   logic [LOGN-1:0]   s_q;
   logic [LOGN-1:0]   d_q;
   logic              vh_q;
   logic              wr_match_q;
   logic              wready_q;
   logic [31:0]       wdata_q;

   logic [LOGN-1:0]   dec_s;
   logic [LOGN-1:0]   dec_d;
   logic              dec_vh;
   logic              dec_err;

   prog_addr_decode #(.LOGN(LOGN)) u_dec (
      .addr_i (cmd_addr),
      .s_o    (dec_s),
      .d_o    (dec_d),
      .vh_o   (dec_vh),
      .err_o  (dec_err)
   );

   // Next sweep index; the sweep ends on all-ones so this never wraps in use
   always_comb begin
      idx_d = idx_q + 1'b1;
   end

   // Control FSM; every output is set on the transition into the state that owns it
   always_ff @(posedge clk) begin
      if (axi_rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         lat_q       <= '0;
         is_wr_q     <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         s_q         <= '0;
         d_q         <= '0;
         vh_q        <= 1'b0;
         wr_match_q  <= 1'b0;
         wready_q    <= 1'b0;
         wdata_q     <= '0;
      end else begin
         done_q   <= 1'b0;
         wready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sweep_start) begin
                  state_q     <= ST_SWEEP_SETUP;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  idx_q       <= '0;
                  s_q         <= '0;
                  d_q         <= '0;
                  vh_q        <= 1'b0;
                  wdata_q     <= sweep_wdata;
                  wr_match_q  <= 1'b1;
               end else if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  is_wr_q     <= cmd_write;
                  if (dec_err) begin
                     state_q     <= ST_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else begin
                     state_q    <= ST_SETUP;
                     s_q        <= dec_s;
                     d_q        <= dec_d;
                     vh_q       <= dec_vh;
                     wdata_q    <= cmd_wdata;
                     wr_match_q <= 1'b1;
                  end
               end
            end
            ST_SETUP: begin
               if (is_wr_q) begin
                  state_q  <= ST_STROBE;
                  wready_q <= 1'b1;
               end else begin
                  state_q <= ST_RWAIT;
                  lat_q   <= LAT_INIT;
               end
            end
            ST_STROBE: begin
               state_q     <= ST_RESP;
               wr_match_q  <= 1'b0;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
            end
            ST_RWAIT: begin
               if (lat_q == '0) begin
                  state_q     <= ST_RESP;
                  wr_match_q  <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= rdata;
               end else begin
                  lat_q <= lat_q - 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= '0;
                  cmd_ready_q <= 1'b1;
               end
            end
            ST_SWEEP_SETUP: begin
               state_q  <= ST_SWEEP_STROBE;
               wready_q <= 1'b1;
            end
            ST_SWEEP_STROBE: begin
               if (idx_q == '1) begin
                  state_q     <= ST_IDLE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  wr_match_q  <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end else begin
                  state_q <= ST_SWEEP_SETUP;
                  idx_q   <= idx_d;
                  d_q     <= idx_d[D_LSB +: LOGN];
                  s_q     <= idx_d[S_LSB +: LOGN];
                  vh_q    <= idx_d[VH_BIT];
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               cmd_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               wr_match_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;
   assign sweep_busy = busy_q;
   assign sweep_done = done_q;
   assign s_addr     = {1'b0, s_q};
   assign d_addr     = {1'b0, d_q};
   assign vh         = vh_q;
   assign wr_match   = wr_match_q;
   assign wready     = wready_q;
   assign wdata      = wdata_q;

endmodule

// File: doc/matrix_prog_ctrl.md
MATRIX_PROG_CTRL -- requirements
Module: matrix_prog_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning matrix dimension; power of two, at least 2.
REQ-002 SHALL have parameter RD_LAT, default 1, meaning the number of cycles from address setup to valid matrix rdata; range 1..4.
REQ-003 SHALL have localparam LOGN = $clog2(N).
REQ-004 SHALL have port clk  input  1  clock; single clock domain.
REQ-005 SHALL have port axi_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have cmd_valid/cmd_ready  in/out  1  command handshake.
REQ-007 SHALL have cmd_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have cmd_addr  input  32  [LOGN-1:0] = d_addr, [2LOGN-1:LOGN] = s_addr, [2LOGN] = vh, higher bits = must be zero.
REQ-009 SHALL have cmd_wdata  input  32  write data.
REQ-010 SHALL have rsp_valid/rsp_ready  out/in  1  response handshake.
REQ-011 SHALL have rsp_rdata  output  32  read data; 0 for writes.
REQ-012 SHALL have rsp_err  output  1  address-decode error.
REQ-013 SHALL have sweep_start  input  1  pulse that starts a full-matrix fill.
REQ-014 SHALL have sweep_wdata  input  32  fill value, sampled at start.
REQ-015 SHALL have sweep_busy / sweep_done  output  1  busy level / one-cycle done pulse.
REQ-016 SHALL have matrix-side outputs s_addr [LOGN:0], d_addr [LOGN:0], vh 1, wr_match 1, wready 1, wdata 32, and input rdata 32; the extra top address bit is always driven 0.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, STROBE, RWAIT, RESP, SWEEP_SETUP, SWEEP_STROBE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid&cmd_ready.
REQ-019 On accept with nonzero high address bits, the FSM SHALL go directly to RESP with rsp_err=1, rsp_rdata=0, and no matrix access (wr_match stays 0).
REQ-020 On a valid accept, the FSM SHALL register s_addr/d_addr/vh/wdata and enter SETUP; wr_match SHALL be 1 throughout SETUP, STROBE, and RWAIT.
REQ-021 For a write, SETUP SHALL proceed to STROBE, where wready=1 for exactly one cycle, then go to RESP.
REQ-022 For a read, SETUP SHALL proceed to RWAIT, hold there RD_LAT-1 cycles (a counter), and capture rdata into rsp_rdata on the final RWAIT cycle, then go to RESP. With RD_LAT=1, RWAIT is a single capture cycle.
REQ-023 In RESP, rsp_valid SHALL be 1 with data stable until rsp_ready, then return to IDLE; cmd_ready SHALL return the cycle after that.
REQ-024 Latency SHALL be: write accept to rsp_valid 3 cycles; read accept to rsp_valid 2+RD_LAT cycles; error accept to rsp_valid 1 cycle.
REQ-025 sweep_start in IDLE SHALL have priority over a simultaneous cmd_valid; the command is not accepted that cycle.
REQ-026 sweep_start outside IDLE SHALL be ignored.
REQ-027 The sweep SHALL write sweep_wdata to every (vh, s, d) triple in order: d fastest, then s, then vh, each as a SWEEP_SETUP then SWEEP_STROBE pair, for 2*N*N writes and 4*N*N cycles.
REQ-028 sweep_busy SHALL be 1 from the cycle after sweep_start through the last SWEEP_STROBE.
REQ-029 sweep_done SHALL pulse one cycle on return to IDLE after the sweep.
REQ-030 The sweep counter SHALL be 2LOGN+1 bits, and SHALL terminate on the all-ones index without wrap.
REQ-031 wready SHALL never be 1 unless wr_match is 1 in the same cycle.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 axi_rst SHALL force IDLE, clear the sweep counter, and set all outputs to 0, except cmd_ready=1, on the next edge.
REQ-034 Reset mid-write or mid-sweep SHALL abort at once with no further wready pulse; no response is generated for the aborted command.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the address-field offsets (D_LSB=0, S_LSB=LOGN, VH_BIT=2LOGN), so firmware-side models decode identically.
REQ-036 One sub-module, prog_addr_decode, SHALL be the combinational split of cmd_addr into s/d/vh/err.

Verification
REQ-037 With N=8, write addr 0x05A (vh=1, s=3, d=2) data 0xDEADBEEF: s_addr=3, d_addr=2, vh=1, one wready pulse, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-038 With RD_LAT=2, read 0x05A while a stub returns 0x12345678: rsp_rdata=0x12345678 4 cycles after accept.
REQ-039 Command with addr 0x100: rsp_err=1 after 1 cycle, wr_match never asserted.
REQ-040 Sweep with N=4, data 0x3: exactly 32 wready pulses covering every triple once, sweep_busy for 64 cycles, one sweep_done pulse.
REQ-041 sweep_start together with cmd_valid: the sweep runs and the command is accepted only after sweep_done; axi_rst at sweep write 10 leaves all outputs 0 next cycle and no further wready.
REQ-042 rsp_ready held low for 5 cycles: rsp_valid/rsp_rdata stable and cmd_ready=0 throughout.
